mcpu_alu_sequencer: RTL and testbench

- Multi-cycle execute controller; it is the issuing side of the MCPU ALU interface.
- Accepts 16-bit instructions over a valid/ready handshake and reads operands from an internal 4x16 register file.
- Drives ALU command and operands, waits a fixed settle time, then writes the ALU result and carry flag back.
- Sits between the instruction fetch stage and the combinational ALU.

---
 rtl/mcpu_alu_sequencer.sv | 119 +++++++++++
 tb/tb_mcpu_alu_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_alu_sequencer.sv
// Multi-cycle execute controller for the MCPU: accepts an instruction, drives the
// combinational ALU for SETTLE_CYCLES, then writes the result back to a 4x16 register file.
module mcpu_alu_sequencer #(
    parameter int WORD_SIZE     = 16,
    parameter int CMD_SIZE      = 3,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          instr,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    output logic [CMD_SIZE-1:0]  alu_cmd,
    output logic [WORD_SIZE-1:0] alu_in1,
    output logic [WORD_SIZE-1:0] alu_in2,
    input  logic [WORD_SIZE-1:0] alu_out,
    input  logic                 alu_cf,
    output logic                 done,
    output logic                 cf,
    input  logic [1:0]           dbg_sel,
    output logic [WORD_SIZE-1:0] dbg_data
);
    // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready;
    // instr_ready is high only in S_IDLE and instr must be stable while instr_valid is high.

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

    state_t               state;
    state_t               state_next;
    logic [15:0]          ir;
    logic [3:0]           settle_cnt;
    logic [WORD_SIZE-1:0] rf [4];

    logic [2:0]           op;
    logic [1:0]           rd;
    logic [1:0]           rs1;
    logic [1:0]           rs2;
    logic                 is_ldi;
    logic [WORD_SIZE-1:0] imm;

    assign op     = ir[15:13];
    assign rd     = ir[12:11];
    assign rs1    = ir[10:9];
    assign rs2    = ir[8:7];
    assign is_ldi = (op == 3'd7);
    assign imm    = {{(WORD_SIZE-11){1'b0}}, ir[10:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (instr_valid) begin
                    state_next = (instr[15:13] == 3'd7) ? S_WB : S_ISSUE;
                end
            end
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (settle_cnt == 4'd0) state_next = S_WB;
            S_WB:    state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state == S_IDLE);
        done        = (state == S_WB);
    end

    // Datapath: operands are captured once in S_ISSUE and held until the next ALU issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir         <= '0;
            settle_cnt <= '0;
            alu_cmd    <= '0;
            alu_in1    <= '0;
            alu_in2    <= '0;
            cf         <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                rf[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        ir <= instr;
                    end
                end
                S_ISSUE: begin
                    alu_cmd    <= CMD_SIZE'(op);
                    alu_in1    <= rf[rs1];
                    alu_in2    <= rf[rs2];
                    settle_cnt <= 4'(SETTLE_CYCLES - 1);
                end
                S_WAIT: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                S_WB: begin
                    rf[rd] <= is_ldi ? imm : alu_out;
                    if (op == 3'd3 || op == 3'd6) begin
                        cf <= alu_cf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dbg_data = rf[dbg_sel];

endmodule

// File: tb/tb_mcpu_alu_sequencer.sv
// Bench for mcpu_alu_sequencer: two instances (settle 1 and 3) against a transaction-level
// architectural model, plus hand-computed expectations for the directed program.
module tb_mcpu_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst [2];
    logic [15:0] instr [2];
    logic        instr_valid [2];
    logic        instr_ready [2];
    logic [2:0]  alu_cmd [2];
    logic [15:0] alu_in1 [2];
    logic [15:0] alu_in2 [2];
    logic [15:0] alu_out [2];
    logic        alu_cf [2];
    logic        done [2];
    logic        cf [2];
    logic [1:0]  dbg_sel [2];
    logic [15:0] dbg_data [2];
    logic        hold [2];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mcpu_alu_sequencer #(.WORD_SIZE(16), .CMD_SIZE(3), .SETTLE_CYCLES(1)) u_dut0 (
        .clk(clk), .reset(rst[0]), .instr(instr[0]), .instr_valid(instr_valid[0]),
        .instr_ready(instr_ready[0]), .alu_cmd(alu_cmd[0]), .alu_in1(alu_in1[0]),
        .alu_in2(alu_in2[0]), .alu_out(alu_out[0]), .alu_cf(alu_cf[0]), .done(done[0]),
        .cf(cf[0]), .dbg_sel(dbg_sel[0]), .dbg_data(dbg_data[0])
    );

    mcpu_alu_sequencer #(.WORD_SIZE(16), .CMD_SIZE(3), .SETTLE_CYCLES(3)) u_dut1 (
        .clk(clk), .reset(rst[1]), .instr(instr[1]), .instr_valid(instr_valid[1]),
        .instr_ready(instr_ready[1]), .alu_cmd(alu_cmd[1]), .alu_in1(alu_in1[1]),
        .alu_in2(alu_in2[1]), .alu_out(alu_out[1]), .alu_cf(alu_cf[1]), .done(done[1]),
        .cf(cf[1]), .dbg_sel(dbg_sel[1]), .dbg_data(dbg_data[1])
    );

    // Reference ALU: {carry/borrow, result}.
    function automatic logic [16:0] alu_f(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        case (op)
            3'd0:    return {1'b0, a & b};
            3'd1:    return {1'b0, a | b};
            3'd2:    return {1'b0, a ^ b};
            3'd3:    return {1'b0, a} + {1'b0, b};
            3'd4:    return (b >= 16'd16) ? 17'd0 : {1'b0, a << b};
            3'd5:    return (b >= 16'd16) ? 17'd0 : {1'b0, a >> b};
            3'd6:    return {1'b0, a} - {1'b0, b};
            default: return 17'd0;
        endcase
    endfunction

    always_comb {alu_cf[0], alu_out[0]} = alu_f(alu_cmd[0], alu_in1[0], alu_in2[0]);
    always_comb {alu_cf[1], alu_out[1]} = alu_f(alu_cmd[1], alu_in1[1], alu_in2[1]);

    function automatic int settle_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [10:0] imm);
        return {3'd7, rd, imm};
    endfunction

    function automatic logic [15:0] aop(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs1, input logic [1:0] rs2);
        return {op, rd, rs1, rs2, 7'd0};
    endfunction

    // Architectural model: m_ph counts cycles left until the controller is idle again.
    logic [15:0] m_regs [2][4];
    logic        m_cf [2];
    int          m_ph [2];
    logic        m_isalu [2];
    logic [1:0]  m_rd [2];
    logic [15:0] m_res [2];
    logic        m_wcf [2];
    logic        m_ncf [2];
    logic [2:0]  m_pcmd [2];
    logic [15:0] m_pin1 [2];
    logic [15:0] m_pin2 [2];
    logic [2:0]  m_cmd [2];
    logic [15:0] m_in1 [2];
    logic [15:0] m_in2 [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                for (int r = 0; r < 4; r++) m_regs[k][r] = 16'd0;
                m_cf[k] = 1'b0; m_ph[k] = 0; m_isalu[k] = 1'b0;
                m_cmd[k] = 3'd0; m_in1[k] = 16'd0; m_in2[k] = 16'd0;
            end else if (m_ph[k] == 0) begin
                if (instr_valid[k]) begin
                    logic [2:0]  op;
                    logic [15:0] a;
                    logic [15:0] b;
                    logic [16:0] r;
                    op = instr[k][15:13];
                    m_rd[k] = instr[k][12:11];
                    if (op == 3'd7) begin
                        m_res[k] = {5'd0, instr[k][10:0]};
                        m_wcf[k] = 1'b0; m_isalu[k] = 1'b0; m_ph[k] = 1;
                    end else begin
                        a = m_regs[k][instr[k][10:9]];
                        b = m_regs[k][instr[k][8:7]];
                        r = alu_f(op, a, b);
                        m_res[k] = r[15:0]; m_ncf[k] = r[16];
                        m_wcf[k] = (op == 3'd3) || (op == 3'd6);
                        m_pcmd[k] = op; m_pin1[k] = a; m_pin2[k] = b;
                        m_isalu[k] = 1'b1; m_ph[k] = settle_of(k) + 2;
                    end
                end
            end else begin
                m_ph[k] = m_ph[k] - 1;
                if (m_isalu[k] && m_ph[k] == settle_of(k) + 1) begin
                    m_cmd[k] = m_pcmd[k]; m_in1[k] = m_pin1[k]; m_in2[k] = m_pin2[k];
                end
                if (m_ph[k] == 0) begin
                    m_regs[k][m_rd[k]] = m_res[k];
                    if (m_wcf[k]) m_cf[k] = m_ncf[k];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Compare process: every cycle, every output against the model; then rotate the debug read.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("ready%0d", k), 32'(instr_ready[k]), 32'(m_ph[k] == 0));
            chk($sformatf("done%0d", k), 32'(done[k]), 32'(m_ph[k] == 1));
            chk($sformatf("cf%0d", k), 32'(cf[k]), 32'(m_cf[k]));
            chk($sformatf("alu_cmd%0d", k), 32'(alu_cmd[k]), 32'(m_cmd[k]));
            chk($sformatf("alu_in1_%0d", k), 32'(alu_in1[k]), 32'(m_in1[k]));
            chk($sformatf("alu_in2_%0d", k), 32'(alu_in2[k]), 32'(m_in2[k]));
            chk($sformatf("dbg%0d_r%0d", k, dbg_sel[k]), 32'(dbg_data[k]),
                32'(m_regs[k][dbg_sel[k]]));
            if (!hold[k]) dbg_sel[k] = dbg_sel[k] + 2'd1;
        end
    end

    task automatic lit_reg(input int k, input logic [1:0] r, input logic [15:0] exp,
                           input string name);
        hold[k] = 1'b1;
        dbg_sel[k] = r;
        #1;
        chk(name, 32'(dbg_data[k]), 32'(exp));
        hold[k] = 1'b0;
    endtask

    task automatic handshake(input int k, input logic [15:0] w);
        int n;
        instr[k] = w;
        instr_valid[k] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_ready[k] && n < 50);
        if (!instr_ready[k]) chk("handshake_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        instr_valid[k] = 1'b0;
    endtask

    task automatic issue(input int k, input logic [15:0] w, input string name);
        int n;
        int lat;
        lat = (w[15:13] == 3'd7) ? 1 : settle_of(k) + 2;
        handshake(k, w);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[k] && n < 50);
        chk({name, "_latency"}, 32'(n), 32'(lat));
        @(posedge clk);
        #1;
    endtask

    logic [15:0] stream [5];

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; instr[k] = 16'd0; instr_valid[k] = 1'b0;
            dbg_sel[k] = 2'd0; hold[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(instr_ready[0]), 32'd1);
        chk("reset_done", 32'(done[0]), 32'd0);
        chk("reset_alu_in1", 32'(alu_in1[0]), 32'd0);
        @(posedge clk);
        #1;

        issue(0, ldi(2'd1, 11'h0FF), "ldi_r1");
        issue(0, ldi(2'd2, 11'h0F0), "ldi_r2");
        issue(0, ldi(2'd3, 11'd4), "ldi_r3");
        issue(0, aop(3'd4, 2'd2, 2'd2, 2'd3), "lsl_build");
        issue(0, ldi(2'd3, 11'h00F), "ldi_r3b");
        issue(0, aop(3'd1, 2'd2, 2'd2, 2'd3), "or_build");
        lit_reg(0, 2'd1, 16'h00FF, "lit_r1_00ff");
        lit_reg(0, 2'd2, 16'h0F0F, "lit_r2_0f0f");
        chk("lit_cf_init", 32'(cf[0]), 32'd0);

        issue(0, ldi(2'd1, 11'h7FF), "ldi_r1b");
        issue(0, ldi(2'd3, 11'd5), "ldi_r3c");
        issue(0, aop(3'd4, 2'd1, 2'd1, 2'd3), "lsl_ffe0");
        issue(0, ldi(2'd3, 11'h01F), "ldi_r3d");
        issue(0, aop(3'd1, 2'd1, 2'd1, 2'd3), "or_ffff");
        issue(0, ldi(2'd2, 11'd1), "ldi_r2b");
        lit_reg(0, 2'd1, 16'hFFFF, "lit_r1_ffff");

        issue(0, aop(3'd3, 2'd3, 2'd1, 2'd2), "add_wrap");
        lit_reg(0, 2'd3, 16'h0000, "lit_add_r3");
        chk("lit_add_cf", 32'(cf[0]), 32'd1);
        chk("lit_add_cmd", 32'(alu_cmd[0]), 32'd3);
        chk("lit_add_in1", 32'(alu_in1[0]), 32'hFFFF);
        chk("lit_add_in2", 32'(alu_in2[0]), 32'h0001);

        issue(0, aop(3'd6, 2'd0, 2'd2, 2'd1), "sub_borrow");
        lit_reg(0, 2'd0, 16'h0002, "lit_sub_r0");
        chk("lit_sub_cf", 32'(cf[0]), 32'd1);
        issue(0, aop(3'd0, 2'd0, 2'd1, 2'd2), "and");
        lit_reg(0, 2'd0, 16'h0001, "lit_and_r0");
        chk("lit_and_cf_kept", 32'(cf[0]), 32'd1);
        issue(0, aop(3'd2, 2'd0, 2'd1, 2'd2), "xor");
        lit_reg(0, 2'd0, 16'hFFFE, "lit_xor_r0");

        issue(0, ldi(2'd2, 11'h010), "ldi_r2_16");
        issue(0, aop(3'd4, 2'd3, 2'd2, 2'd2), "lsl_by16");
        lit_reg(0, 2'd3, 16'h0000, "lit_lsl16_r3");
        issue(0, ldi(2'd3, 11'h0FF), "ldi_r3_ff");
        issue(0, ldi(2'd2, 11'd4), "ldi_r2_4");
        issue(0, aop(3'd5, 2'd3, 2'd3, 2'd2), "lsr");
        lit_reg(0, 2'd3, 16'h000F, "lit_lsr_r3");
        issue(0, aop(3'd6, 2'd0, 2'd3, 2'd2), "sub_noborrow");
        lit_reg(0, 2'd0, 16'h000B, "lit_sub2_r0");
        chk("lit_sub2_cf", 32'(cf[0]), 32'd0);

        // Abort an ADD with reset while it is in its settle window.
        handshake(0, aop(3'd3, 2'd3, 2'd1, 2'd2));
        @(posedge clk);
        #1;
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(instr_ready[0]), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("abort_no_done", 32'(done[0]), 32'd0);
            @(negedge clk);
        end
        lit_reg(0, 2'd3, 16'h0000, "lit_abort_r3");
        chk("abort_cf", 32'(cf[0]), 32'd0);

        // Continuous instr_valid on the settle-3 instance.
        stream[0] = ldi(2'd1, 11'd5);
        stream[1] = ldi(2'd2, 11'd3);
        stream[2] = aop(3'd3, 2'd3, 2'd1, 2'd2);
        stream[3] = aop(3'd3, 2'd3, 2'd3, 2'd3);
        stream[4] = aop(3'd6, 2'd0, 2'd3, 2'd1);
        @(posedge clk);
        #1;
        instr[1] = stream[0];
        instr_valid[1] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            int n;
            @(posedge clk);
            #1;
            if (i < 4) instr[1] = stream[i+1];
            else instr_valid[1] = 1'b0;
            n = 0;
            forever begin
                @(negedge clk);
                if (instr_ready[1] || n >= 40) break;
                n++;
            end
            chk($sformatf("stream_busy_%0d", i), 32'(n), (stream[i][15:13] == 3'd7) ? 32'd1 : 32'd5);
        end
        lit_reg(1, 2'd1, 16'd5, "lit_stream_r1");
        lit_reg(1, 2'd3, 16'd16, "lit_stream_r3");
        lit_reg(1, 2'd0, 16'd11, "lit_stream_r0");
        chk("lit_stream_cf", 32'(cf[1]), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
